// File: rtl/ct_readout_regs.sv
// Ciphertext read-back bank: captures a 128-bit result, serves it as four clear-on-read words.
// Read latency 1 cycle, no backpressure; unread data is zeroed on flush, overrun or timeout scrub.
module ct_readout_regs #(
  parameter int SCRUB_TIMEOUT = 1024,
  parameter int WORD_BASE     = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ct_valid_i,
  input  logic [127:0] ct_i,
  input  logic [3:0]   reglk_ctrl_i,
  input  logic         flush_i,
  input  logic         en,
  input  logic         re,
  input  logic [31:0]  address,
  output logic [31:0]  rdata,
  output logic         rvalid,
  output logic [3:0]   ct_full_o,
  output logic         ready_o,
  output logic         lock_err_o,
  output logic         overrun_o,
  output logic         scrub_o
);

  localparam int TW = $clog2(SCRUB_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCRUB_TIMEOUT - 1);

  typedef enum logic [1:0] {EMPTY, HELD, SCRUB} state_t;

  state_t        state_q, state_d;
  logic [31:0]   ct_q [4];
  logic [3:0]    full_q;
  logic [TW-1:0] timer_q;

  logic          accept, in_range, locked, hit, timeout, capture, read_clr;
  logic [6:0]    off;
  logic [1:0]    k;
  logic [3:0]    full_rd;
  logic          addr_unused;

  assign addr_unused = ^{address[31:9], address[2:0]};

  // WORD_BASE maps to word 3, so the word index is the inverted offset.
  assign off      = {1'b0, address[8:3]} - 7'(WORD_BASE);
  assign in_range = (off < 7'd4);
  assign k        = ~off[1:0];

  always_comb begin
    accept   = en && re;
    locked   = accept && in_range && reglk_ctrl_i[k];
    hit      = accept && in_range && !reglk_ctrl_i[k] && full_q[k];
    timeout  = (state_q == HELD) && (timer_q == TIMER_LAST);
    capture  = ct_valid_i && !flush_i && !timeout;
    read_clr = hit && !flush_i && !timeout && !ct_valid_i;
    full_rd  = full_q & ~(read_clr ? (4'b0001 << k) : 4'b0000);

    state_d = state_q;
    case (state_q)
      EMPTY: if (ct_valid_i) state_d = HELD;
      HELD: begin
        if (timeout)              state_d = SCRUB;
        else if (ct_valid_i)      state_d = HELD;
        else if (full_rd == 4'h0) state_d = EMPTY;
      end
      SCRUB:   state_d = ct_valid_i ? HELD : EMPTY;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      for (int i = 0; i < 4; i++) ct_q[i] <= '0;
      full_q     <= '0;
      timer_q    <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      lock_err_o <= 1'b0;
      overrun_o  <= 1'b0;
      scrub_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rvalid     <= accept;
      lock_err_o <= locked;
      // Read data is the pre-edge word; flush and scrub win and return zero.
      rdata      <= (hit && !flush_i && !timeout) ? ct_q[k] : '0;
      overrun_o  <= capture && (state_q == HELD);
      scrub_o    <= timeout && !flush_i;

      if (flush_i || timeout) begin
        for (int i = 0; i < 4; i++) ct_q[i] <= '0;
        full_q  <= '0;
        timer_q <= '0;
      end else if (capture) begin
        for (int i = 0; i < 4; i++) ct_q[i] <= ct_i[32*i +: 32];
        full_q  <= 4'hF;
        timer_q <= '0;
      end else begin
        if (read_clr) begin
          ct_q[k] <= '0;
          full_q  <= full_rd;
        end
        if (state_q == HELD) begin
          if (full_rd == 4'h0)       timer_q <= '0;
          else if (timer_q != '1)    timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  assign ct_full_o = full_q;
  assign ready_o   = (state_q == EMPTY);

endmodule

// File: doc/ct_readout_regs.md
Name: ct_readout_regs

Overview:
Read-side register bank for the crypto engine result. It captures the 128-bit ciphertext when the core signals completion and serves it to software as four 32-bit bus-readable words. Each word is cleared as soon as it is read. Any words left unread are zeroed on flush, on timeout or on overrun, so stale result data never lingers. It sits beside the plaintext/key write bank and reuses the same reglk_ctrl_i lock vector and address[8:3] word decode.

Parameters:
SCRUB_TIMEOUT, 1024, cycles the block may stay in HELD before an unconditional scrub (must be >= 2).
WORD_BASE, 5, value of address[8:3] that selects word 3. WORD_BASE+1..WORD_BASE+3 select words 2, 1 and 0.

Ports:
clk_i  input  1  clock; all logic on posedge.
rst_i  input  1  synchronous, active-high reset.
ct_valid_i  input  1  one-cycle pulse: ct_i holds a finished result.
ct_i  input  128  ciphertext. Word k = ct_i[32k+31:32k].
reglk_ctrl_i  input  4  read lock per word; bit k locks word k.
flush_i  input  1  synchronous clear of all held data.
en  input  1  bus select.
re  input  1  read strobe; a read is accepted when en && re.
address  input  32  bus address; only [8:3] decoded.
rdata  output  32  read data, valid when rvalid=1, otherwise 0.
rvalid  output  1  one-cycle read response pulse.
ct_full_o  output  4  bit k = word k holds unread data.
ready_o  output  1  1 when state is EMPTY.
lock_err_o  output  1  one-cycle pulse: accepted read hit a locked word.
overrun_o  output  1  one-cycle pulse: ct_valid_i arrived while in HELD.
scrub_o  output  1  one-cycle pulse: timeout scrub performed.

Behaviour:
- Reset (rst_i=1 at an edge):
  - ct_q[0:3], ct_full_o, rdata, rvalid, timer and all pulse outputs go to 0.
  - State goes to EMPTY, so ready_o=1.
  - rst_i overrides every other input in the same cycle.
- Priority per edge: rst_i > flush_i > timeout scrub > ct_valid_i capture > read-clear.
- States:
  - EMPTY: all words and full bits are 0.
  - HELD: ct_full_o != 0.
  - SCRUB: single cycle.
- EMPTY + ct_valid_i: ct_q <= ct_i, full <= 4'hF, timer <= 0, next state HELD.
- HELD:
  - Timer increments every cycle.
  - When timer == SCRUB_TIMEOUT-1, next state is SCRUB.
  - When the last full bit clears through a read, next state is EMPTY and the timer resets.
- SCRUB: zero ct_q and full, pulse scrub_o on the same edge, next state EMPTY. Total residence in HELD is exactly SCRUB_TIMEOUT cycles.
- flush_i in any state: zero ct_q, full and timer; next state EMPTY; no scrub_o pulse.
- Overrun (ct_valid_i while in HELD):
  - ct_q <= ct_i, full <= 4'hF, timer <= 0, overrun_o pulses.
  - Old words are never merged with new ones.
- Read, accepted at edge N; response in the cycle after edge N:
  - Response: rvalid=1 for exactly one cycle, then 0.
  - Decoded word k, full[k]=1, reglk_ctrl_i[k]=0: rdata = pre-edge ct_q[k]; at edge N, ct_q[k] <= 0 and full[k] <= 0.
  - Word k locked: rdata=0, lock_err_o pulses with rvalid, word and full bit unchanged.
  - Word k empty, or address[8:3] outside WORD_BASE..WORD_BASE+3: rdata=0, no error.
- Simultaneous events at the same edge:
  - Read + capture/overrun: the read returns pre-edge data (0 if EMPTY). The capture wins, so full=4'hF afterwards.
  - Read + scrub, or read + flush: rdata=0, rvalid=1.
- Back-to-back reads are allowed every cycle; there is no backpressure.
- Timer width is $clog2(SCRUB_TIMEOUT); the timer saturates and never wraps.

Test Plan:
1. Reset, then ct_valid_i with ct_i=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210. Read address[8:3]=5,6,7,8 on consecutive cycles -> rdata 32'h01234567, 89ABCDEF, FEDCBA98, 76543210, each one cycle after its read. ct_full_o steps F,7,3,1,0; ready_o=1 after the last read. A re-read of word 3 -> rdata 0.
2. Capture, then set reglk_ctrl_i=4'b1000 and read word 3 -> rdata 0, lock_err_o=1, ct_full_o stays F. Clear the lock and re-read -> rdata 32'h01234567.
3. Capture with SCRUB_TIMEOUT=16 and no reads -> scrub_o pulses exactly 16 cycles after capture, ct_full_o=0, and a following read of word 0 -> rdata 0.
4. Capture A, read word 0, then ct_valid_i with B -> overrun_o=1, ct_full_o=F, and every read returns B's words.
5. Capture, then assert flush_i in the same cycle as a read of word 2 -> rdata 0, rvalid 1, ct_full_o 0, ready_o 1, no scrub_o pulse.
6. Capture, read 2 words, then assert rst_i together with ct_valid_i -> all outputs 0 and ready_o=1, with no capture.
